sensor_emu: RTL and testbench

SENSOR_EMU -- requirements
Module: sensor_emu

---
 rtl/sensor_pkg.sv | 15 +
 rtl/sync2.sv | 25 ++
 rtl/sensor_emu.sv | 130 +++++++++++++
 tb/tb_sensor_emu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the light-sensor serial emulator: FSM state
// encoding and default frame geometry.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEFAULT_FRAME_BITS = 16;
  localparam int DEFAULT_LEAD_ZEROS = 3;
  localparam int SAMPLE_BITS        = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a parameterised reset level, used to bring the
// master's ncs and sck into the clk domain.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two back-to-back flops; both reset to the idle level of the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sensor_emu.sv
// Light-sensor serial emulator. Presents an 8-bit sample inside a
// FRAME_BITS-long frame on sdo, MSB first, framed by ncs and clocked by sck
// (sck idles high; sdo launched on sck fall, sampled by the master on rise).
// Macro SENSOR_EMU_SYNC_EN: pass ncs/sck through sync2 synchronizers
// (asynchronous master). Undefined: a single register stage (master on clk).
// state_dbg exposes the FSM state for checkers.
module sensor_emu
  import sensor_pkg::*;
#(
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
  parameter int LEAD_ZEROS = DEFAULT_LEAD_ZEROS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ncs,
  input  logic                   sck,
  output logic                   sdo,
  input  logic [SAMPLE_BITS-1:0] sample,
  output logic                   busy,
  output logic                   frame_done,
  output state_e                 state_dbg
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TAIL  = FRAME_BITS - LEAD_ZEROS - SAMPLE_BITS;

  logic ncs_s, sck_s;   // clk-domain copies of the pins
  logic ncs_d, sck_d;   // previous samples for edge detection
  logic ncs_fall, ncs_rise, sck_fall, sck_rise;

`ifdef SENSOR_EMU_SYNC_EN
  sync2 #(.RST_VAL(1'b1)) u_ncs_sync (.clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s));
  sync2 #(.RST_VAL(1'b1)) u_sck_sync (.clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s));
`else
  // Single register stage; master shares clk so no metastability concern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_s <= 1'b1;
      sck_s <= 1'b1;
    end else begin
      ncs_s <= ncs;
      sck_s <= sck;
    end
  end
`endif

  // Edge-detect history, reset to the idle-high levels of ncs and sck.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_d <= 1'b1;
      sck_d <= 1'b1;
    end else begin
      ncs_d <= ncs_s;
      sck_d <= sck_s;
    end
  end

  assign ncs_fall = ncs_d & ~ncs_s;
  assign ncs_rise = ~ncs_d & ncs_s;
  assign sck_fall = sck_d & ~sck_s;
  assign sck_rise = ~sck_d & sck_s;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_d;
  logic [FRAME_BITS-1:0] load_word;

  assign load_word = {{(FRAME_BITS-SAMPLE_BITS){1'b0}}, sample} << TAIL;

  // FSM state, shift register, bit counter and frame_done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      frame_done <= done_d;
    end
  end

  // Next-state logic. An ncs rise beats any simultaneous sck edge. The very
  // first sck fall of a frame launches the already-loaded MSB, so shifting
  // only starts once at least one bit has been sampled by the master.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          shreg_d = load_word;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sck_fall && (cnt_q != '0)) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end else if (sck_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(FRAME_BITS)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ncs_rise) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo       = (state_q == SHIFT) & shreg_q[FRAME_BITS-1];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sensor_emu.sv
// Bench for sensor_emu (default build, single register stage on ncs/sck).
// A frame-level model predicts sdo/busy/frame_done every cycle; directed
// frames also check the word the master collects against literal values.
module tb_sensor_emu;
  import sensor_pkg::*;

  localparam int FB   = 16;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ncs = 1'b1;
  logic       sck = 1'b1;
  logic [7:0] sample = 8'h00;
  logic       sdo, busy, frame_done;
  state_e     state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Clock.
  always #5 clk = ~clk;

  sensor_emu dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sck(sck), .sdo(sdo),
    .sample(sample), .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame opens when the master's ncs goes low, the
  // word is the sample placed after LEAD_ZEROS zeros, the n-th sck fall puts
  // bit n of the word (MSB = bit 1) on sdo, and after FB sck rises the frame
  // is complete. Pin changes reach the outputs two clk edges later.
  bit         m_valid = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  int         m_rises = 0;
  int         m_falls = 0;
  logic [15:0] m_word = '0;
  logic       n1 = 1'b1, n2 = 1'b1, s1 = 1'b1, s2 = 1'b1;

  always @(posedge clk) begin
    m_done = 0;
    if (!rst_n) begin
      m_active = 0; m_rises = 0; m_falls = 0;
      n1 = 1'b1; n2 = 1'b1; s1 = 1'b1; s2 = 1'b1;
      m_valid = 1;
    end else begin
      if (!m_active) begin
        if (n2 && !n1) begin
          m_active = 1; m_word = 16'(sample) << 5; m_rises = 0; m_falls = 0;
        end
      end else if (!n2 && n1) begin
        if (m_rises >= FB) m_done = 1;
        m_active = 0;
      end else if (m_rises < FB) begin
        if (s2 && !s1) m_falls++;
        if (!s2 && s1) m_rises++;
      end
      n2 = n1; n1 = ncs; s2 = s1; s1 = sck;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (m_valid) begin
      int   idx;
      logic exp_sdo;
      idx = (m_falls == 0) ? 0 : m_falls - 1;
      exp_sdo = (m_active && m_rises < FB && idx < FB) ? m_word[FB-1-idx] : 1'b0;
      check("sdo", 32'(sdo), 32'(exp_sdo));
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(m_done));
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // Driver tasks.
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] s, input int pulses, input int change_at,
                       input logic [7:0] s_new, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    sample = s;
    ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < pulses; i++) begin
      sck = 1'b0;
      wait_clks(HALF);
      rx = {rx[30:0], sdo};
      sck = 1'b1;
      if (i + 1 == change_at) sample = s_new;
      wait_clks(HALF);
    end
    ncs = 1'b1;
    wait_clks(10);
  endtask

  initial begin
    logic [31:0] rx;
    int          d0;

    // Reset state.
    wait_clks(3);
    check("reset_sdo", 32'(sdo), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    wait_clks(5);

    // A5 single frame.
    d0 = done_cnt;
    frame(8'hA5, 16, 0, 8'h00, rx);
    check("word_a5", rx[15:0], 32'h14A0);
    check("bits_12_5_a5", 32'(rx[12:5]), 32'hA5);
    check("done_a5", done_cnt - d0, 1);

    // Back-to-back 00 then FF.
    d0 = done_cnt;
    frame(8'h00, 16, 0, 8'h00, rx);
    check("word_00", rx[15:0], 32'h0000);
    frame(8'hFF, 16, 0, 8'h00, rx);
    check("word_ff", rx[15:0], 32'h1FE0);
    check("done_00_ff", done_cnt - d0, 2);

    // Sample changes mid-frame; captured value kept.
    d0 = done_cnt;
    frame(8'h3C, 16, 4, 8'hC3, rx);
    check("word_3c_kept", rx[15:0], 32'h0780);
    check("done_3c", done_cnt - d0, 1);

    // Aborted frame after 7 rises, then a full frame.
    d0 = done_cnt;
    frame(8'h55, 7, 0, 8'h00, rx);
    check("abort_done", done_cnt - d0, 0);
    check("abort_busy", 32'(busy), 32'd0);
    frame(8'h81, 16, 0, 8'h00, rx);
    check("word_81", rx[15:0], 32'h1020);
    check("done_81", done_cnt - d0, 1);

    // Reset asserted mid-frame.
    d0 = done_cnt;
    @(negedge clk);
    sample = 8'h99;
    ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b0; wait_clks(HALF);
      sck = 1'b1; wait_clks(HALF);
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    wait_clks(1);
    check("midreset_sdo", 32'(sdo), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ncs = 1'b1;
    wait_clks(10);
    check("midreset_done", done_cnt - d0, 0);
    frame(8'h5A, 16, 0, 8'h00, rx);
    check("word_5a_after_reset", rx[15:0], 32'h0B40);
    check("done_5a", done_cnt - d0, 1);

    // Extra sck pulses: 20 instead of 16.
    d0 = done_cnt;
    frame(8'hA5, 20, 0, 8'h00, rx);
    check("word_extra_first16", 32'(rx[19:4]), 32'h14A0);
    check("word_extra_tail", 32'(rx[3:0]), 32'h0);
    check("done_extra", done_cnt - d0, 1);

    wait_clks(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
